mc_control_unit: RTL
====================

# mc_control_unit

Multicycle control unit for the RISC-V core: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback steps and drives every datapath select and enable. It is the producing end of the ALU's 3-bit ALUControl interface; its encoding here is binding on the ALU. It sits between the instruction register (op/funct fields) and the shared-memory multicycle datapath.

## Interface
- No parameters; all widths fixed by RV32I.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  instruction opcode (Instr[6:0])
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction/OldPC register enable
- RegWrite  out  1  register-file write enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1
- ALUSrcB  out  2  00=WriteData, 01=ImmExt, 10=constant 4
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 110 sra; 111 = unsupported (ALU yields 0)

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL (+HALT, see Configuration).
- Transitions: FETCH->DECODE. DECODE: op 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BEQ, 1101111->JAL, other->FETCH. MEMADR: lw->MEMREAD, sw->MEMWRITE. MEMREAD->MEMWB->FETCH. MEMWRITE->FETCH. EXECR, EXECI, JAL->ALUWB->FETCH. BEQ->FETCH.
- State outputs (unlisted signals = 0):
  - FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1, ALUOp=00.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1. MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1.
  - EXECR: ALUSrcA=10, ALUOp=10. EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: RegWrite=1.
  - BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
- PCWrite = PCUpdate | (Branch & Zero).
- ImmSrc, combinational from op only: I/lw 00, sw 01, beq 10, jal 11, anything else 00.
- ALU decode from ALUOp/funct3:
  - ALUOp 00->000 and 01->001.
  - ALUOp 10 by funct3:
    - 000: 001 if op[5]&funct7b5, else 000.
    - 010->101. 110->011. 111->010.
    - 101: 110 if funct7b5, else 111 (srl unsupported).
    - Any other funct3->111.
- ALUOp 11 is never generated. If it is forced, ALUControl=111.

## Timing
- State register is updated on posedge clk. Outputs are combinational from state, plus op/funct/Zero where listed.
- Reset asserted asynchronously forces state=FETCH immediately, including mid-instruction. While rst_n=0, outputs show FETCH values (IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, ALUControl=000, rest 0). The datapath is held in reset at the same time, so these are harmless.
- Cycles per instruction: lw 5, sw 4, R/I-ALU 4, jal 4, beq 3, unknown opcode 2.
- Zero is sampled only in BEQ, in the same cycle. PCWrite follows Zero with no delay.
- op/funct must be stable from DECODE until return to FETCH. They are taken from the IR, which is written only in FETCH.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined:
  - DECODE with an unlisted opcode, or MEMADR with an op that is neither lw nor sw, goes to HALT.
  - HALT self-loops with all enables 0 and drives extra output IllegalInstr=1. Only rst_n exits HALT.
- CTRL_ILLEGAL_TRAP_EN undefined: no HALT state and no IllegalInstr port. Unknown opcodes return to FETCH, i.e. they behave as a 2-cycle NOP.

## Structure
- Package ctrl_pkg holds:
  - the state enum;
  - opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - ALUOp codes;
  - ALUControl codes, shared with the ALU.
- Sub-module alu_decoder, purely combinational: ALUOp, funct3, op[5], funct7b5 -> ALUControl.
- The FSM and ImmSrc decode live in mc_control_unit.

## Test plan
- Reset mid-MEMREAD (rst_n low for 1 cycle) -> state FETCH on the same edge; IRWrite=1, PCWrite=1 next cycle.
- lw (op 0000011) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01; ImmSrc=00.
- R-type sub (funct3 000, funct7b5=1) -> ALUControl=001 in EXECR; add (funct7b5=0) -> 000; addi with funct7b5=1 -> 000.
- srai (op 0010011, funct3 101, funct7b5=1) -> ALUControl=110; srl (funct7b5=0) -> 111.
- beq with Zero=1 -> PCWrite=1 in BEQ, 3-cycle instruction; with Zero=0 -> PCWrite=0 throughout BEQ.
- op 0110111 (lui) -> without macro, FETCH, DECODE, FETCH; with CTRL_ILLEGAL_TRAP_EN, HALT with IllegalInstr=1 held for 10 cycles until rst_n.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit and the ALU it drives.
// The HALT state exists only when CTRL_ILLEGAL_TRAP_EN is defined.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL
`ifdef CTRL_ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SRA  = 3'b110;
    localparam logic [2:0] ALU_NONE = 3'b111;

endpackage

// File: rtl/mc_control_unit_if.sv
// Instruction-field inputs and datapath control outputs of mc_control_unit.
// IllegalInstr is present only when CTRL_ILLEGAL_TRAP_EN is defined.
interface mc_control_unit_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       IllegalInstr;
`endif

    modport master (
`ifdef CTRL_ILLEGAL_TRAP_EN
        output IllegalInstr,
`endif
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
    );

    modport slave (
`ifdef CTRL_ILLEGAL_TRAP_EN
        input  IllegalInstr,
`endif
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
    );
endinterface

// File: rtl/mc_control_unit_alu_decoder.sv
// Combinational ALU decoder: ALUOp plus instruction fields to ALUControl.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op_b5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);
    always_comb begin
        alu_control = ALU_NONE;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op[5] separates R-type sub from addi, whose bit 30 is immediate data
                    3'b000:  alu_control = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_NONE;
                    default: alu_control = ALU_NONE;
                endcase
            end
            default: alu_control = ALU_NONE;
        endcase
    end
endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RV32I control unit: Moore FSM, ImmSrc decode and ALU decoder.
// Define CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes in a HALT state.
module mc_control_unit
    import ctrl_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    mc_control_unit_if.master bus
);
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_t S_ILLEGAL = S_HALT;
`else
    localparam state_t S_ILLEGAL = S_FETCH;
`endif

    state_t     state_q, state_d;
    logic       pc_update, branch;
    logic       adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic [2:0] alu_control;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (bus.op == OP_LW)      state_d = S_MEMREAD;
                else if (bus.op == OP_SW) state_d = S_MEMWRITE;
                else                      state_d = S_ILLEGAL;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        imm_src = 2'b00;
        case (bus.op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (bus.funct3),
        .op_b5       (bus.op[5]),
        .funct7b5    (bus.funct7b5),
        .alu_control (alu_control)
    );

    assign bus.PCWrite    = pc_update | (branch & bus.Zero);
    assign bus.AdrSrc     = adr_src;
    assign bus.MemWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.RegWrite   = reg_write;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ImmSrc     = imm_src;
    assign bus.ALUControl = alu_control;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign bus.IllegalInstr = (state_q == S_HALT);
`endif
endmodule
